// File: rtl/apb_cmd_master.sv
// APB initiator: queues read/write commands in a small FIFO and issues them in
// order as SETUP/ACCESS transfers, returning a one-cycle response per transfer.
module apb_cmd_master #(
   parameter int AMBA_WORD       = 32,
   parameter int AMBA_ADDR_WIDTH = 20,
   parameter int CMD_FIFO_DEPTH  = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       cmd_valid,
   output logic                       cmd_ready,
   input  logic                       cmd_write,
   input  logic [AMBA_ADDR_WIDTH-1:0] cmd_addr,
   input  logic [AMBA_WORD-1:0]       cmd_wdata,
   output logic                       rsp_valid,
   output logic                       rsp_write,
   output logic [AMBA_WORD-1:0]       rsp_rdata,
   output logic                       busy,
   output logic                       PSEL,
   output logic                       PENABLE,
   output logic                       PWRITE,
   output logic [AMBA_ADDR_WIDTH-1:0] PADDR,
   output logic [AMBA_WORD-1:0]       PWDATA,
   input  logic [AMBA_WORD-1:0]       PRDATA
);

   localparam int PW = $clog2(CMD_FIFO_DEPTH);
   localparam int CW = PW + 1;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETUP  = 2'd1;
   localparam logic [1:0] ST_ACCESS = 2'd2;

   // command FIFO
   logic                       mem_w [CMD_FIFO_DEPTH];
   logic [AMBA_ADDR_WIDTH-1:0] mem_a [CMD_FIFO_DEPTH];
   logic [AMBA_WORD-1:0]       mem_d [CMD_FIFO_DEPTH];
   logic [PW-1:0]              wptr_q, rptr_q;
   logic [CW-1:0]              cnt_q, cnt_d;
   logic                       push, pop, fifo_ne;

   logic [1:0]                 state_q, state_d;
   logic                       psel_q, psel_d, pen_q, pen_d, pwrite_q, pwrite_d;
   logic [AMBA_ADDR_WIDTH-1:0] paddr_q, paddr_d;
   logic [AMBA_WORD-1:0]       pwdata_q, pwdata_d;
   logic                       rsp_valid_q, rsp_valid_d, rsp_write_q, rsp_write_d;
   logic [AMBA_WORD-1:0]       rsp_rdata_q, rsp_rdata_d;

   // Gating with rst keeps cmd_ready low while reset is held.
   assign cmd_ready = rst & (cnt_q < CW'(CMD_FIFO_DEPTH));
   assign fifo_ne   = (cnt_q != '0);
   assign push      = cmd_valid & cmd_ready;
   assign pop       = fifo_ne & ((state_q == ST_IDLE) | (state_q == ST_ACCESS));

   always_comb begin
      cnt_d = cnt_q;
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_w[wptr_q] <= cmd_write;
         mem_a[wptr_q] <= cmd_addr;
         mem_d[wptr_q] <= cmd_wdata;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         if (push) wptr_q <= wptr_q + PW'(1);
         if (pop)  rptr_q <= rptr_q + PW'(1);
         cnt_q <= cnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      psel_d      = psel_q;
      pen_d       = pen_q;
      pwrite_d    = pwrite_q;
      paddr_d     = paddr_q;
      pwdata_d    = pwdata_q;
      rsp_valid_d = 1'b0;
      rsp_write_d = rsp_write_q;
      rsp_rdata_d = rsp_rdata_q;
      case (state_q)
         ST_IDLE: begin
            if (pop) begin
               state_d = ST_SETUP;
               psel_d  = 1'b1;
               pen_d   = 1'b0;
            end
         end
         ST_SETUP: begin
            state_d = ST_ACCESS;
            pen_d   = 1'b1;
         end
         ST_ACCESS: begin
            rsp_valid_d = 1'b1;
            rsp_write_d = pwrite_q;
            if (!pwrite_q) rsp_rdata_d = PRDATA;
            pen_d = 1'b0;
            if (pop) begin
               state_d = ST_SETUP;
            end else begin
               state_d = ST_IDLE;
               psel_d  = 1'b0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            psel_d  = 1'b0;
            pen_d   = 1'b0;
         end
      endcase
      // the popped head becomes the next transfer's address phase
      if (pop) begin
         pwrite_d = mem_w[rptr_q];
         paddr_d  = mem_a[rptr_q];
         pwdata_d = mem_d[rptr_q];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         psel_q      <= 1'b0;
         pen_q       <= 1'b0;
         pwrite_q    <= 1'b0;
         paddr_q     <= '0;
         pwdata_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_write_q <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         psel_q      <= psel_d;
         pen_q       <= pen_d;
         pwrite_q    <= pwrite_d;
         paddr_q     <= paddr_d;
         pwdata_q    <= pwdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_write_q <= rsp_write_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   assign busy      = (state_q != ST_IDLE) | fifo_ne;
   assign PSEL      = psel_q;
   assign PENABLE   = pen_q;
   assign PWRITE    = pwrite_q;
   assign PADDR     = paddr_q;
   assign PWDATA    = pwdata_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_write = rsp_write_q;
   assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Bench for apb_cmd_master: a command-level reference model predicts the bus
// transfers and responses, and a passive monitor logs what the DUT actually did.
module tb_apb_cmd_master;
   localparam int AW = 20;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          cmd_valid, cmd_ready, cmd_write;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_wdata;
   logic          rsp_valid, rsp_write;
   logic [DW-1:0] rsp_rdata;
   logic          busy, PSEL, PENABLE, PWRITE;
   logic [AW-1:0] PADDR;
   logic [DW-1:0] PWDATA, PRDATA;
   logic [DW-1:0] prdata_xor;

   always #5 clk = ~clk;

   apb_cmd_master #(.AMBA_WORD(DW), .AMBA_ADDR_WIDTH(AW), .CMD_FIFO_DEPTH(4)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
      .busy(busy), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
      .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA));

   // slave read data is a fixed function of the address
   function automatic logic [DW-1:0] slv(input logic [AW-1:0] a);
      return {12'h0, a} ^ prdata_xor;
   endfunction
   assign PRDATA = slv(PADDR);

   typedef struct { logic w; logic [AW-1:0] a; logic [DW-1:0] d; int cyc; } xfer_t;
   typedef struct { logic w; logic [DW-1:0] r; int cyc; } rsp_t;

   xfer_t exp_q[$], acc_q[$];
   rsp_t  erq[$], rsp_q[$];
   int    setup_q[$];
   int    cyc = 0;
   int    checks = 0, failures = 0;
   logic [DW-1:0] mdl_rdata;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rst) begin
         if (PSEL && !PENABLE) setup_q.push_back(cyc);
         if (PSEL && PENABLE)  acc_q.push_back('{PWRITE, PADDR, PWDATA, cyc});
         if (rsp_valid)        rsp_q.push_back('{rsp_write, rsp_rdata, cyc});
      end
   end

   task automatic clear_obs();
      acc_q.delete(); rsp_q.delete(); setup_q.delete(); exp_q.delete(); erq.delete();
   endtask

   // Expected responses: in order, reads return the slave word, writes keep the last read value.
   task automatic model_run();
      erq.delete();
      foreach (exp_q[i]) begin
         if (!exp_q[i].w) mdl_rdata = slv(exp_q[i].a);
         erq.push_back('{exp_q[i].w, mdl_rdata, 0});
      end
   endtask

   // Offers one command from negedge+1; returns with the handshake edge index.
   task automatic push(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d, output int hs);
      bit acc = 0;
      hs = -1;
      cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
      for (int t = 0; t < 100 && !acc; t++) begin
         acc = cmd_ready;
         @(negedge clk); #1;
      end
      cmd_valid = 1'b0;
      if (!acc) begin
         checks++; failures++;
         $display("FAIL push_timeout cmd_ready stuck at 0, required 1");
      end else begin
         hs = cyc;
         exp_q.push_back('{w, a, d, hs});
      end
   endtask

   task automatic wait_drain();
      bit done = 0;
      for (int t = 0; t < 400 && !done; t++) begin
         @(negedge clk); #1;
         done = !busy;
      end
      if (!done) begin
         checks++; failures++;
         $display("FAIL drain_timeout busy=%0b required 0", busy);
      end
      @(negedge clk); #1;
   endtask

   task automatic test_reset();
      rst = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
      prdata_xor = '0; mdl_rdata = '0;
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if ({cmd_ready, busy, PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_write, rsp_rdata} !== '0) begin
         failures++;
         $display("FAIL reset_outputs rdy=%0b busy=%0b psel=%0b pen=%0b paddr=%h pwdata=%h rsp_v=%0b rdata=%h required all 0",
                  cmd_ready, busy, PSEL, PENABLE, PADDR, PWDATA, rsp_valid, rsp_rdata);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_release cmd_ready=%0b busy=%0b required 1/0", cmd_ready, busy);
      end
      @(negedge clk); #1;
   endtask

   task automatic test_single_write();
      int hs;
      clear_obs();
      push(1'b1, 20'h00000, 32'h0000_0002, hs);
      wait_drain();
      model_run();
      checks++;
      if (setup_q.size() != 1 || acc_q.size() != 1 || rsp_q.size() != 1) begin
         failures++;
         $display("FAIL wr_counts setup=%0d access=%0d rsp=%0d required 1/1/1", setup_q.size(), acc_q.size(), rsp_q.size());
      end else begin
         checks++;
         if (setup_q[0] != hs + 1 || acc_q[0].cyc != hs + 2 || rsp_q[0].cyc != hs + 3) begin
            failures++;
            $display("FAIL wr_latency setup=%0d access=%0d rsp=%0d required %0d/%0d/%0d",
                     setup_q[0], acc_q[0].cyc, rsp_q[0].cyc, hs + 1, hs + 2, hs + 3);
         end
         checks++;
         if ({acc_q[0].w, acc_q[0].a, acc_q[0].d} !== {1'b1, 20'h00000, 32'h2}) begin
            failures++;
            $display("FAIL wr_bus w=%0b a=%h d=%h required 1/00000/00000002", acc_q[0].w, acc_q[0].a, acc_q[0].d);
         end
         checks++;
         if (rsp_q[0].w !== 1'b1 || rsp_q[0].r !== 32'h0) begin
            failures++;
            $display("FAIL wr_rsp write=%0b rdata=%h required 1/00000000", rsp_q[0].w, rsp_q[0].r);
         end
      end
   endtask

   task automatic test_single_read();
      int hs;
      clear_obs();
      prdata_xor = 32'hDEADBEEF ^ 32'h4;
      push(1'b0, 20'h00004, $urandom(), hs);
      wait_drain();
      model_run();
      checks++;
      if (rsp_q.size() != 1 || acc_q.size() != 1) begin
         failures++;
         $display("FAIL rd_counts access=%0d rsp=%0d required 1/1", acc_q.size(), rsp_q.size());
      end else begin
         checks++;
         if (rsp_q[0].cyc != hs + 3 || rsp_q[0].w !== 1'b0 || rsp_q[0].r !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL rd_rsp cyc=%0d write=%0b rdata=%h required %0d/0/deadbeef",
                     rsp_q[0].cyc, rsp_q[0].w, rsp_q[0].r, hs + 3);
         end
         checks++;
         if (acc_q[0].a !== 20'h4 || acc_q[0].w !== 1'b0) begin
            failures++;
            $display("FAIL rd_bus a=%h w=%0b required 00004/0", acc_q[0].a, acc_q[0].w);
         end
      end
   endtask

   task automatic test_back_to_back();
      int hs;
      clear_obs();
      prdata_xor = 32'h1234_0000;
      push(1'b1, 20'h0, 32'h11, hs);
      push(1'b0, 20'h4, $urandom(), hs);
      push(1'b1, 20'h8, 32'h33, hs);
      wait_drain();
      model_run();
      checks++;
      if (setup_q.size() != 3 || acc_q.size() != 3 || rsp_q.size() != 3) begin
         failures++;
         $display("FAIL b2b_counts setup=%0d access=%0d rsp=%0d required 3/3/3", setup_q.size(), acc_q.size(), rsp_q.size());
      end else begin
         for (int k = 0; k < 3; k++) begin
            checks++;
            if (setup_q[k] != setup_q[0] + 2*k || acc_q[k].cyc != setup_q[0] + 2*k + 1 || rsp_q[k].cyc != setup_q[0] + 2*k + 2) begin
               failures++;
               $display("FAIL b2b_timing[%0d] setup=%0d access=%0d rsp=%0d required %0d/%0d/%0d", k,
                        setup_q[k], acc_q[k].cyc, rsp_q[k].cyc, setup_q[0] + 2*k, setup_q[0] + 2*k + 1, setup_q[0] + 2*k + 2);
            end
            checks++;
            if ({acc_q[k].w, acc_q[k].a, acc_q[k].d} !== {exp_q[k].w, exp_q[k].a, exp_q[k].d} ||
                {rsp_q[k].w, rsp_q[k].r} !== {erq[k].w, erq[k].r}) begin
               failures++;
               $display("FAIL b2b_data[%0d] bus=%0b/%h/%h rsp=%0b/%h required %0b/%h/%h rsp=%0b/%h", k,
                        acc_q[k].w, acc_q[k].a, acc_q[k].d, rsp_q[k].w, rsp_q[k].r,
                        exp_q[k].w, exp_q[k].a, exp_q[k].d, erq[k].w, erq[k].r);
            end
         end
      end
   endtask

   task automatic test_full_fifo();
      int n_acc = 0, stalls = 0, maxocc = 0, occ;
      logic rdy;
      clear_obs();
      prdata_xor = $urandom();
      for (int t = 0; t < 300 && n_acc < 10; t++) begin
         cmd_valid = 1'b1; cmd_write = n_acc[0]; cmd_addr = AW'(16 * n_acc + 4); cmd_wdata = 32'hC0DE_0000 + n_acc;
         occ = n_acc - setup_q.size();
         if (occ > maxocc) maxocc = occ;
         checks++;
         if (cmd_ready !== (occ < 4)) begin
            failures++;
            $display("FAIL full_ready cyc=%0d cmd_ready=%0b required %0b (occupancy %0d)", cyc, cmd_ready, occ < 4, occ);
         end
         rdy = cmd_ready;
         if (!rdy) stalls++;
         @(negedge clk); #1;
         if (rdy) begin
            exp_q.push_back('{cmd_write, cmd_addr, cmd_wdata, cyc});
            n_acc++;
         end
      end
      cmd_valid = 1'b0;
      wait_drain();
      model_run();
      checks++;
      if (stalls == 0 || maxocc != 4) begin
         failures++;
         $display("FAIL full_backpressure stalls=%0d max_occupancy=%0d required >0/4", stalls, maxocc);
      end
      checks++;
      if (acc_q.size() != exp_q.size() || rsp_q.size() != erq.size()) begin
         failures++;
         $display("FAIL full_counts access=%0d rsp=%0d required %0d/%0d", acc_q.size(), rsp_q.size(), exp_q.size(), erq.size());
      end else begin
         foreach (exp_q[k]) begin
            checks++;
            if ({acc_q[k].w, acc_q[k].a, acc_q[k].d} !== {exp_q[k].w, exp_q[k].a, exp_q[k].d} ||
                {rsp_q[k].w, rsp_q[k].r} !== {erq[k].w, erq[k].r}) begin
               failures++;
               $display("FAIL full_order[%0d] bus=%h rsp=%0b/%h required %h rsp=%0b/%h", k,
                        acc_q[k].a, rsp_q[k].w, rsp_q[k].r, exp_q[k].a, erq[k].w, erq[k].r);
            end
         end
      end
   endtask

   task automatic test_reset_mid_access();
      int hs;
      clear_obs();
      push(1'b0, 20'h10, 32'h1, hs);
      push(1'b1, 20'h14, 32'h2, hs);
      push(1'b0, 20'h18, 32'h3, hs);
      checks++;
      if (PSEL !== 1'b1 || PENABLE !== 1'b1 || busy !== 1'b1) begin
         failures++;
         $display("FAIL rstmid_pre psel=%0b pen=%0b busy=%0b required 1/1/1", PSEL, PENABLE, busy);
      end
      rst = 1'b0;
      #1;
      checks++;
      if ({PSEL, PENABLE, busy, rsp_valid, cmd_ready} !== 5'b0) begin
         failures++;
         $display("FAIL rstmid_async psel=%0b pen=%0b busy=%0b rsp_v=%0b rdy=%0b required all 0",
                  PSEL, PENABLE, busy, rsp_valid, cmd_ready);
      end
      repeat (2) @(negedge clk);
      #1;
      rst = 1'b1; mdl_rdata = '0;
      clear_obs();
      repeat (8) @(negedge clk);
      #1;
      checks++;
      if (setup_q.size() != 0 || acc_q.size() != 0 || rsp_q.size() != 0 || busy !== 1'b0 ||
          cmd_ready !== 1'b1 || rsp_rdata !== 32'h0) begin
         failures++;
         $display("FAIL rstmid_after setup=%0d access=%0d rsp=%0d busy=%0b rdy=%0b rdata=%h required 0/0/0/0/1/0",
                  setup_q.size(), acc_q.size(), rsp_q.size(), busy, cmd_ready, rsp_rdata);
      end
   endtask

   // wrap=1: 10 reads with PRDATA equal to the address; wrap=0: random mixed traffic with gaps
   task automatic test_stream(input bit wrap, input int n);
      int hs;
      logic w;
      clear_obs();
      prdata_xor = wrap ? '0 : $urandom();
      for (int i = 0; i < n; i++) begin
         w = wrap ? 1'b0 : 1'($urandom_range(0, 1));
         push(w, wrap ? AW'(4 * i + 32'h100) : AW'($urandom()), $urandom(), hs);
         if (!wrap) repeat ($urandom_range(0, 2)) begin @(negedge clk); #1; end
      end
      wait_drain();
      model_run();
      checks++;
      if (acc_q.size() != n || rsp_q.size() != n) begin
         failures++;
         $display("FAIL stream%0d_counts access=%0d rsp=%0d required %0d", wrap, acc_q.size(), rsp_q.size(), n);
      end else begin
         for (int k = 0; k < n; k++) begin
            checks++;
            if ({acc_q[k].w, acc_q[k].a, acc_q[k].d} !== {exp_q[k].w, exp_q[k].a, exp_q[k].d} ||
                {rsp_q[k].w, rsp_q[k].r} !== {erq[k].w, erq[k].r}) begin
               failures++;
               $display("FAIL stream%0d[%0d] bus=%0b/%h/%h rsp=%0b/%h required %0b/%h/%h rsp=%0b/%h", wrap, k,
                        acc_q[k].w, acc_q[k].a, acc_q[k].d, rsp_q[k].w, rsp_q[k].r,
                        exp_q[k].w, exp_q[k].a, exp_q[k].d, erq[k].w, erq[k].r);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_single_read();
      test_back_to_back();
      test_full_fifo();
      test_reset_mid_access();
      test_stream(1'b1, 10);
      test_stream(1'b0, 24);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
